// File: rtl/countdown_timer_pkg.sv
// Shared types and digit limits for the MM:SS countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t S1_MAX = 4'd9;
  localparam bcd_t M1_MAX = 4'd9;

endpackage

// File: rtl/countdown_timer_bcd_digit_down.sv
// One BCD digit of the countdown chain: decrements on borrow, wrapping 0 to LIMIT.
module bcd_digit_down
  import timer_pkg::*;
#(
  parameter int LIMIT = 9
) (
  input  bcd_t d,
  input  logic borrowIn,
  output bcd_t q,
  output logic borrowOut
);

  localparam bcd_t LIM = bcd_t'(LIMIT);

  // Next digit value and borrow towards the more significant digit
  always_comb begin
    q         = d;
    borrowOut = 1'b0;
    if (borrowIn) begin
      if (d == 4'd0) begin
        q         = LIM;
        borrowOut = 1'b1;
      end else begin
        q         = d - 4'd1;
        borrowOut = 1'b0;
      end
    end else begin
      q         = d;
      borrowOut = 1'b0;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer driven by rising edges of the divided slowClk wave,
// with load/start/pause control, a one-cycle done pulse and an expired level.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int MAX_M10 = 9,
  parameter int MAX_S10 = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tickIn,
  input  logic        load,
  input  logic [15:0] loadValue,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] digits,
  output logic        running,
  output logic        done,
  output logic        expired
);

  localparam bcd_t M10_LIM = bcd_t'(MAX_M10);
  localparam bcd_t S10_LIM = bcd_t'(MAX_S10);

  function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t lim);
    return (d > lim) ? lim : d;
  endfunction

  function automatic logic [15:0] sanitize(input logic [15:0] v);
    return {clamp_digit(v[15:12], M10_LIM), clamp_digit(v[11:8], M1_MAX),
            clamp_digit(v[7:4], S10_LIM), clamp_digit(v[3:0], S1_MAX)};
  endfunction

  timer_state_t state_r;
  logic         tick_prev_r;
  logic         tick_s;
  logic         dec_en_s;
  bcd_t         s1_q_s, s10_q_s, m1_q_s, m10_q_s;
  logic         s1_b_s, s10_b_s, m1_b_s, m10_b_s;
  logic [15:0]  dec_value_s;
  logic         dec_zero_s;

  assign tick_s   = tickIn & ~tick_prev_r;
  assign dec_en_s = tick_s & (state_r == RUNNING);

  bcd_digit_down #(.LIMIT(int'(S1_MAX))) u_s1 (
    .d(digits[3:0]), .borrowIn(dec_en_s), .q(s1_q_s), .borrowOut(s1_b_s)
  );
  bcd_digit_down #(.LIMIT(MAX_S10)) u_s10 (
    .d(digits[7:4]), .borrowIn(s1_b_s), .q(s10_q_s), .borrowOut(s10_b_s)
  );
  bcd_digit_down #(.LIMIT(int'(M1_MAX))) u_m1 (
    .d(digits[11:8]), .borrowIn(s10_b_s), .q(m1_q_s), .borrowOut(m1_b_s)
  );
  bcd_digit_down #(.LIMIT(MAX_M10)) u_m10 (
    .d(digits[15:12]), .borrowIn(m1_b_s), .q(m10_q_s), .borrowOut(m10_b_s)
  );

  assign dec_value_s = {m10_q_s, m1_q_s, s10_q_s, s1_q_s};
  // A borrow out of the top digit would mean counting below 00:00; treat it as expiry.
  assign dec_zero_s  = (dec_value_s == 16'h0000) | m10_b_s;

  // Control FSM, digit register and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      digits      <= 16'h0000;
      running     <= 1'b0;
      done        <= 1'b0;
      expired     <= 1'b0;
      tick_prev_r <= 1'b1;
    end else begin
      tick_prev_r <= tickIn;
      done        <= 1'b0;
      if (load) begin
        digits  <= sanitize(loadValue);
        state_r <= IDLE;
        running <= 1'b0;
        expired <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (!pause && start && (digits != 16'h0000)) begin
              state_r <= RUNNING;
              running <= 1'b1;
            end
          end
          RUNNING: begin
            if (pause) begin
              state_r <= PAUSED;
              running <= 1'b0;
            end else if (tick_s) begin
              if (dec_zero_s) begin
                digits  <= 16'h0000;
                state_r <= EXPIRED;
                running <= 1'b0;
                expired <= 1'b1;
                done    <= 1'b1;
              end else begin
                digits <= dec_value_s;
              end
            end
          end
          PAUSED: begin
            if (!pause && start) begin
              state_r <= RUNNING;
              running <= 1'b1;
            end
          end
          EXPIRED: begin
            digits <= 16'h0000;
          end
          default: begin
            state_r <= IDLE;
            running <= 1'b0;
            expired <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with hand-computed expectations.
module tb_countdown_timer;

  logic        clk;
  logic        reset;
  logic        tickIn;
  logic        load;
  logic [15:0] loadValue;
  logic        start;
  logic        pause;
  logic [15:0] digits;
  logic        running;
  logic        done;
  logic        expired;

  int checks = 0;
  int errors = 0;

  countdown_timer #(.MAX_M10(9), .MAX_S10(5)) dut (
    .clk(clk), .reset(reset), .tickIn(tickIn), .load(load), .loadValue(loadValue),
    .start(start), .pause(pause), .digits(digits), .running(running),
    .done(done), .expired(expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    step(); loadValue = v; load = 1'b1;
    step(); load = 1'b0;
  endtask

  task automatic do_start();
    step(); start = 1'b1;
    step(); start = 1'b0;
  endtask

  task automatic do_pause();
    step(); pause = 1'b1;
    step(); pause = 1'b0;
  endtask

  // One rising edge of tickIn; returns at the first sample after the decrement edge.
  task automatic do_tick();
    step(); tickIn = 1'b1;
    step(); tickIn = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tickIn = 1'b0; load = 1'b0; loadValue = 16'h0000;
    start = 1'b0; pause = 1'b0;
    step(); step();
    chk("rst_digits", digits, 16'h0000);
    chk("rst_running", {15'd0, running}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_expired", {15'd0, expired}, 16'd0);
    reset = 1'b0;

    // Basic countdown to expiry
    do_load(16'h0003);
    chk("basic_load", digits, 16'h0003);
    do_start();
    chk("basic_running", {15'd0, running}, 16'd1);
    do_tick();
    chk("basic_t1", digits, 16'h0002);
    chk("basic_t1_done", {15'd0, done}, 16'd0);
    do_tick();
    chk("basic_t2", digits, 16'h0001);
    do_tick();
    chk("basic_t3", digits, 16'h0000);
    chk("basic_done", {15'd0, done}, 16'd1);
    chk("basic_expired", {15'd0, expired}, 16'd1);
    chk("basic_run_off", {15'd0, running}, 16'd0);
    step();
    chk("basic_done_once", {15'd0, done}, 16'd0);
    do_tick();
    chk("exp_hold", digits, 16'h0000);
    chk("exp_no_done", {15'd0, done}, 16'd0);
    do_start();
    chk("exp_start_ign", {15'd0, running}, 16'd0);
    chk("exp_still", {15'd0, expired}, 16'd1);

    // Borrow chain
    do_load(16'h1000);
    chk("load_clr_exp", {15'd0, expired}, 16'd0);
    do_start(); do_tick();
    chk("borrow_1000", digits, 16'h0959);
    do_load(16'h0100);
    do_start(); do_tick();
    chk("borrow_0100", digits, 16'h0059);

    // Clamp of out-of-range digits
    do_load(16'hAB7C);
    chk("clamp", digits, 16'h9959);
    do_start(); do_tick();
    chk("clamp_tick", digits, 16'h9958);

    // Pause / resume
    do_load(16'h0010);
    do_start(); do_tick(); do_tick();
    chk("pause_pre", digits, 16'h0008);
    do_pause();
    chk("pause_run", {15'd0, running}, 16'd0);
    do_tick(); do_tick(); do_tick();
    chk("pause_hold", digits, 16'h0008);
    do_start();
    chk("resume_run", {15'd0, running}, 16'd1);
    do_tick();
    chk("resume_tick", digits, 16'h0007);
    step(); tickIn = 1'b1; pause = 1'b1;
    step(); tickIn = 1'b0; pause = 1'b0;
    chk("pause_tick_same", digits, 16'h0007);
    chk("pause_tick_run", {15'd0, running}, 16'd0);
    step(); start = 1'b1; pause = 1'b1;
    step(); start = 1'b0; pause = 1'b0;
    chk("start_pause_both", {15'd0, running}, 16'd0);
    step(); start = 1'b1; tickIn = 1'b1;
    step(); start = 1'b0; tickIn = 1'b0;
    chk("resume_tick_ign", digits, 16'h0007);
    chk("resume_run2", {15'd0, running}, 16'd1);

    // Start at zero is ignored
    do_load(16'h0000);
    do_start();
    chk("zero_start_run", {15'd0, running}, 16'd0);
    do_tick();
    chk("zero_start_done", {15'd0, done}, 16'd0);
    chk("zero_start_exp", {15'd0, expired}, 16'd0);

    // Load coincident with tick while running
    do_load(16'h0005);
    do_start();
    step(); tickIn = 1'b1; load = 1'b1; loadValue = 16'h0042;
    step(); tickIn = 1'b0; load = 1'b0;
    chk("load_tick_val", digits, 16'h0042);
    chk("load_tick_idle", {15'd0, running}, 16'd0);
    do_tick();
    chk("idle_tick_ign", digits, 16'h0042);

    // Reset mid-count with tickIn held high
    do_start(); do_tick();
    chk("pre_reset", digits, 16'h0041);
    step(); tickIn = 1'b1; reset = 1'b1;
    step();
    chk("reset_digits", digits, 16'h0000);
    chk("reset_running", {15'd0, running}, 16'd0);
    chk("reset_expired", {15'd0, expired}, 16'd0);
    reset = 1'b0;
    do_load(16'h0030);
    do_start();
    step(); step();
    chk("post_reset_notick", digits, 16'h0030);
    step(); tickIn = 1'b0;
    do_tick();
    chk("post_reset_tick", digits, 16'h0029);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
